// File: rtl/fsm_rd_burst_pkg.sv
// fsm_rd_burst_pkg: state encoding shared by the read-burst FSM
// Contents: STATE_W state width, state_e with XXX for X-assignment
package fsm_rd_burst_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    DLY  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4,
    XXX  = 'x
  } state_e;
endpackage

// File: rtl/fsm_rd_burst.sv
// fsm_rd_burst: registered read-burst handshake FSM with per-beat wait timeout and abort
// Ports: clk, rst_n (async low) | go, len (beats-1), ws (wait-state), abort |
//        rd, ds, last, busy, err, beat (all registered)
// Macro FSM_RD_BURST_XPROP_EN: illegal state drives X instead of recovering to IDLE
module fsm_rd_burst
  import fsm_rd_burst_pkg::*;
#(
  parameter int LEN_W    = 4,
  parameter int MAX_WAIT = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [LEN_W-1:0] len,
  input  logic             ws,
  input  logic             abort,
  output logic             rd,
  output logic             ds,
  output logic             last,
  output logic             busy,
  output logic             err,
  output logic [LEN_W-1:0] beat
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  state_e r_state, w_state;
  logic [LEN_W-1:0] r_len, w_len, r_beat, w_beat;
  logic [WAIT_W-1:0] r_wcnt, w_wcnt;
  logic r_rd, w_rd, r_ds, w_ds, r_last, w_last, r_busy, w_busy, r_err, w_err;
  always_comb begin
    w_state = r_state;
    w_len   = r_len;
    w_beat  = r_beat;
    w_wcnt  = r_wcnt;
    w_rd    = 1'b0;
    w_ds    = 1'b0;
    w_last  = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      IDLE: if (go && !abort) begin
        w_state = READ;
        w_len   = len;
        w_beat  = '0;
        w_wcnt  = '0;
        w_rd    = 1'b1;
      end
      READ: begin
        w_state = DLY;
        w_rd    = 1'b1;
      end
      DLY: if (!ws) begin
        w_ds   = 1'b1;
        w_wcnt = '0;
        if (r_beat == r_len) begin
          w_last  = 1'b1;
          w_state = DONE;
        end else begin
          w_beat  = r_beat + LEN_W'(1);
          w_rd    = 1'b1;
          w_state = READ;
        end
      end else if (r_wcnt == WAIT_W'(MAX_WAIT - 1)) begin
        w_err   = 1'b1;
        w_state = ERR;
      end else begin
        w_wcnt  = r_wcnt + WAIT_W'(1);
        w_rd    = 1'b1;
        w_state = READ;
      end
      DONE, ERR: w_state = IDLE;
      default: begin
`ifdef FSM_RD_BURST_XPROP_EN
        w_state = XXX;
        w_rd    = 1'bx;
        w_ds    = 1'bx;
        w_last  = 1'bx;
        w_err   = 1'bx;
`else
        w_state = IDLE;
`endif
      end
    endcase
    // abort outranks beat completion and timeout; beat index is kept for inspection
    if (abort && r_state != IDLE) begin
      w_state = IDLE;
      w_beat  = r_beat;
      w_rd    = 1'b0;
      w_ds    = 1'b0;
      w_last  = 1'b0;
      w_err   = 1'b0;
    end
    w_busy = (w_state != IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_beat  <= '0;
      r_wcnt  <= '0;
      r_rd    <= 1'b0;
      r_ds    <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_len   <= w_len;
      r_beat  <= w_beat;
      r_wcnt  <= w_wcnt;
      r_rd    <= w_rd;
      r_ds    <= w_ds;
      r_last  <= w_last;
      r_busy  <= w_busy;
      r_err   <= w_err;
    end
  end
  assign rd   = r_rd;
  assign ds   = r_ds;
  assign last = r_last;
  assign busy = r_busy;
  assign err  = r_err;
  assign beat = r_beat;
endmodule

// File: tb/tb_fsm_rd_burst.sv
// tb_fsm_rd_burst: directed scoreboard bench for fsm_rd_burst (LEN_W=4, MAX_WAIT=7)
module tb_fsm_rd_burst;
  typedef struct packed {
    logic rd, ds, last, busy, err;
    logic [3:0] beat;
  } out_t;
  logic clk = 1'b0, rst_n = 1'b0, go = 1'b0, ws = 1'b0, abort = 1'b0;
  logic [3:0] len = '0, beat;
  logic rd, ds, last, busy, err;
  out_t obs, q[$];
  int errs = 0, checks = 0;
  fsm_rd_burst #(.LEN_W(4), .MAX_WAIT(7)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .len(len), .ws(ws), .abort(abort),
    .rd(rd), .ds(ds), .last(last), .busy(busy), .err(err), .beat(beat)
  );
  assign obs = {rd, ds, last, busy, err, beat};
  always #5 clk = ~clk;
  function automatic out_t o(logic r, logic d, logic l, logic b, logic e, int bt);
    return {r, d, l, b, e, 4'(bt)};
  endfunction
  task automatic cmp(string tag);
    out_t e;
    e = q.pop_front();
    checks++;
    assert (obs === e) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b (rd ds last busy err beat)", tag, obs, e);
    end
  endtask
  task automatic step(string tag, logic g, int l, logic w, logic a, out_t e);
    go = g;
    len = 4'(l);
    ws = w;
    abort = a;
    q.push_back(e);
    @(posedge clk);
    #1;
    cmp(tag);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    q.push_back(o(0, 0, 0, 0, 0, 0));
    cmp("reset");
    rst_n = 1'b1;
    // single beat, no waits
    step("b1_go", 1, 0, 0, 0, o(1, 0, 0, 1, 0, 0));
    step("b1_read", 0, 0, 0, 0, o(1, 0, 0, 1, 0, 0));
    step("b1_ds", 0, 0, 0, 0, o(0, 1, 1, 1, 0, 0));
    step("b1_done", 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0));
    step("b1_idle", 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0));
    // four beats; go/len during the burst must be ignored
    step("b4_go", 1, 3, 0, 0, o(1, 0, 0, 1, 0, 0));
    for (int k = 0; k < 4; k++) begin
      step("b4_read", k == 1, 9, 0, 0, o(1, 0, 0, 1, 0, k));
      if (k < 3) step("b4_ds", k == 1, 9, 0, 0, o(1, 1, 0, 1, 0, k + 1));
      else step("b4_last", 0, 9, 0, 0, o(0, 1, 1, 1, 0, 3));
    end
    step("b4_done", 0, 0, 0, 0, o(0, 0, 0, 0, 0, 3));
    step("b4_idle", 0, 0, 0, 0, o(0, 0, 0, 0, 0, 3));
    // two beats, MAX_WAIT-1 waits on each: counter restarts per beat, no timeout
    step("w_go", 1, 1, 0, 0, o(1, 0, 0, 1, 0, 0));
    for (int b = 0; b < 2; b++) begin
      step("w_read", 0, 0, 1, 0, o(1, 0, 0, 1, 0, b));
      for (int i = 0; i < 6; i++) begin
        step("w_retry", 0, 0, 1, 0, o(1, 0, 0, 1, 0, b));
        step("w_reread", 0, 0, 1, 0, o(1, 0, 0, 1, 0, b));
      end
      if (b == 0) step("w_ds0", 0, 0, 0, 0, o(1, 1, 0, 1, 0, 1));
      else step("w_ds1", 0, 0, 0, 0, o(0, 1, 1, 1, 0, 1));
    end
    step("w_done", 0, 0, 0, 0, o(0, 0, 0, 0, 0, 1));
    // stuck wait-state: 7th ws sample times out
    step("t_go", 1, 2, 1, 0, o(1, 0, 0, 1, 0, 0));
    for (int i = 0; i < 7; i++) begin
      step("t_read", 0, 0, 1, 0, o(1, 0, 0, 1, 0, 0));
      if (i < 6) step("t_retry", 0, 0, 1, 0, o(1, 0, 0, 1, 0, 0));
      else step("t_err", 0, 0, 1, 0, o(0, 0, 0, 1, 1, 0));
    end
    step("t_idle", 0, 0, 1, 0, o(0, 0, 0, 0, 0, 0));
    step("t_quiet", 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0));
    // abort in READ of beat 2, then an immediate new go
    step("a_go", 1, 5, 0, 0, o(1, 0, 0, 1, 0, 0));
    for (int k = 0; k < 2; k++) begin
      step("a_read", 0, 0, 0, 0, o(1, 0, 0, 1, 0, k));
      step("a_ds", 0, 0, 0, 0, o(1, 1, 0, 1, 0, k + 1));
    end
    step("a_abort", 0, 0, 0, 1, o(0, 0, 0, 0, 0, 2));
    step("a_regoadd", 1, 0, 0, 0, o(1, 0, 0, 1, 0, 0));
    step("a_read2", 0, 0, 0, 0, o(1, 0, 0, 1, 0, 0));
    // abort beats a completing final beat in DLY
    step("a_dly", 0, 0, 0, 1, o(0, 0, 0, 0, 0, 0));
    // abort in IDLE masks go
    step("a_idle", 1, 4, 0, 1, o(0, 0, 0, 0, 0, 0));
    // asynchronous reset in DLY
    step("r_go", 1, 1, 1, 0, o(1, 0, 0, 1, 0, 0));
    step("r_dly", 0, 0, 1, 0, o(1, 0, 0, 1, 0, 0));
    q.push_back(o(0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #1;
    cmp("r_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("r_quiet1", 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0));
    step("r_quiet2", 0, 0, 1, 0, o(0, 0, 0, 0, 0, 0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
